// File: rtl/fpu_dp_pkg.sv
// Shared definitions for the double-precision FPU result path: field
// positions, class encodings and the result FIFO entry layout.
package fpu_dp_pkg;

    localparam int unsigned DP_WIDTH = 64;
    localparam int unsigned EXP_MSB  = 62;
    localparam int unsigned EXP_LSB  = 52;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned MAN_MSB  = 51;
    localparam int unsigned MAN_LSB  = 0;
    localparam int unsigned FLAGS_W  = 2;
    localparam int unsigned CLASS_W  = 2;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 11'h7FF;

    typedef enum logic [CLASS_W-1:0] {
        CLS_FINITE = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    // One queued multiplier result with its class and exception flags
    typedef struct packed {
        logic [DP_WIDTH-1:0] result;
        fp_class_e           cls;
        logic                overflow;
        logic                underflow;
    } result_entry_t;

endpackage

// File: rtl/fpu_dp_classify.sv
// Combinational IEEE-754 double classifier; the sign bit does not affect
// the class, and subnormals count as finite.
module fpu_dp_classify
    import fpu_dp_pkg::*;
(
    input  logic [DP_WIDTH-1:0] word,
    output fp_class_e           class_c
);

    logic [EXP_W-1:0] exp_field;
    logic             man_nonzero;

    assign exp_field   = word[EXP_MSB:EXP_LSB];
    assign man_nonzero = |word[MAN_MSB:MAN_LSB];

    always_comb begin
        class_c = CLS_FINITE;
        if (exp_field == '0 && !man_nonzero) begin
            class_c = CLS_ZERO;
        end else if (exp_field == EXP_ALL_ONES) begin
            class_c = man_nonzero ? CLS_NAN : CLS_INF;
        end
    end

endmodule

// File: rtl/fpu_dp_result_stage.sv
// Result stage after the DP multiplier: classifies each result, queues it
// in a small FIFO, and keeps sticky exception flags and a result counter.
module fpu_dp_result_stage
    import fpu_dp_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_class,
    output logic [1:0]       out_flags,
    output logic             sticky_of,
    output logic             sticky_uf,
    input  logic             flag_clr,
    output logic [15:0]      result_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    result_entry_t    mem [DEPTH];
    result_entry_t    head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;
    fp_class_e        in_class_c;

    fpu_dp_classify u_classify (
        .word    (in_result),
        .class_c (in_class_c)
    );

    // Handshakes come from registered occupancy only; reset forces both low
    assign in_ready  = !rst && (occ < OCC_W'(DEPTH));
    assign out_valid = !rst && (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem[rd_ptr];
    assign out_result = out_valid ? head.result : '0;
    assign out_class  = out_valid ? head.cls : CLASS_W'(0);
    assign out_flags  = out_valid ? {head.overflow, head.underflow} : FLAGS_W'(0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Payload storage needs no reset; outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{result:    DP_WIDTH'(in_result),
                             cls:       in_class_c,
                             overflow:  in_overflow,
                             underflow: in_underflow};
        end
    end

    // A flag-setting push overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_of  <= 1'b0;
            sticky_uf  <= 1'b0;
            result_cnt <= '0;
        end else begin
            sticky_of <= (sticky_of && !flag_clr) || (push && in_overflow);
            sticky_uf <= (sticky_uf && !flag_clr) || (push && in_underflow);
            if (push) begin
                result_cnt <= result_cnt + 16'd1;
            end
        end
    end

endmodule
